mem_sram_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; sits directly downstream of the EXE stage / EXE_Reg.
- Consumes the ALU result as the byte address and the forwarded store operand (src2_val) as store data.
- Performs 32-bit loads and stores on an external 16-bit SRAM as two half-word accesses.
- Drives a ready signal; while ready is low, the hazard/freeze logic stalls all pipeline registers.

---
 rtl/mem_sram_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_sram_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_sram_stage.sv
// MEM stage: 32-bit loads/stores on a 16-bit SRAM as two half-word phases, stalling via ready.
// Optional one-entry last-load cache enabled by defining SRAM_LAST_READ_CACHE_EN.
module mem_sram_stage #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_result,
  input  logic [31:0]            src2_val,
  output logic                   ready,
  output logic [31:0]            mem_read_value,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam int unsigned WW = SRAM_ADDR_W - 1;
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_w_q, op_w_d;
  logic [WW-1:0]          word_q, word_d;
  logic [31:0]            data_q, data_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   oe_q, oe_d;
  logic                   we_n_q, we_n_d;
  logic [31:0]            mrv_q, mrv_d;
  logic                   req;
  logic [WW-1:0]          req_word;

  assign req      = MEM_W_EN | MEM_R_EN;
  // Upper word bits are dropped on purpose: out-of-range addresses wrap.
  assign req_word = WW'((ALU_result - 32'(BASE_ADDR)) >> 2);

`ifdef SRAM_LAST_READ_CACHE_EN
  logic          c_valid_q;
  logic [WW-1:0] c_word_q;
  logic [31:0]   c_data_q;
  logic          c_hit;
  assign c_hit = !MEM_W_EN && c_valid_q && (c_word_q == req_word);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_w_d   = op_w_q;
    word_d   = word_q;
    data_d   = data_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    oe_d     = 1'b0;
    we_n_d   = 1'b1;
    mrv_d    = mrv_q;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !req;
        if (req) begin
          op_w_d = MEM_W_EN;
          word_d = req_word;
          data_d = src2_val;
          cnt_d  = '0;
`ifdef SRAM_LAST_READ_CACHE_EN
          if (c_hit) begin
            mrv_d   = c_data_q;
            state_d = DONE;
          end else
`endif
          begin
            state_d  = LO;
            addr_d   = {req_word, 1'b0};
            dq_out_d = src2_val[15:0];
            oe_d     = MEM_W_EN;
            we_n_d   = !MEM_W_EN;
          end
        end
      end
      LO: begin
        oe_d   = op_w_q;
        we_n_d = !op_w_q;
        if (cnt_q == LAST_CNT) begin
          if (!op_w_q) mrv_d[15:0] = sram_dq_in;
          state_d  = HI;
          cnt_d    = '0;
          addr_d   = {word_q, 1'b1};
          dq_out_d = data_q[31:16];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        oe_d   = op_w_q;
        we_n_d = !op_w_q;
        if (cnt_q == LAST_CNT) begin
          if (!op_w_q) mrv_d[31:16] = sram_dq_in;
          state_d = DONE;
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_w_q   <= 1'b0;
      word_q   <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
      mrv_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_w_q   <= op_w_d;
      word_q   <= word_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      mrv_q    <= mrv_d;
    end
  end

`ifdef SRAM_LAST_READ_CACHE_EN
  // Entry is refreshed when an access retires: loads refill it, same-word stores patch the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_word_q  <= '0;
      c_data_q  <= '0;
    end else if (state_q == DONE) begin
      if (op_w_q) begin
        if (c_valid_q && (c_word_q == word_q)) c_data_q <= data_q;
      end else begin
        c_valid_q <= 1'b1;
        c_word_q  <= word_q;
        c_data_q  <= mrv_q;
      end
    end
  end
`endif

  assign mem_read_value = mrv_q;
  assign sram_addr      = addr_q;
  assign sram_dq_out    = dq_out_q;
  assign sram_dq_oe     = oe_q;
  assign sram_we_n      = we_n_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed bench for mem_sram_stage with a behavioural 16-bit SRAM model.
module tb_mem_sram_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_result, src2_val;
  logic        ready;
  logic [31:0] mem_read_value;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

`ifdef SRAM_LAST_READ_CACHE_EN
  localparam int HIT_LOW = 1;
`else
  localparam int HIT_LOW = 5;
`endif

  logic [15:0] sram_mem [0:(1<<18)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq_out;
      we_cnt <= we_cnt + 1;
    end
  end
  assign sram_dq_in = sram_mem[sram_addr];

  mem_sram_stage dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_R_EN       (mem_r_en),
    .MEM_W_EN       (mem_w_en),
    .ALU_result     (alu_result),
    .src2_val       (src2_val),
    .ready          (ready),
    .mem_read_value (mem_read_value),
    .sram_addr      (sram_addr),
    .sram_dq_out    (sram_dq_out),
    .sram_dq_oe     (sram_dq_oe),
    .sram_dq_in     (sram_dq_in),
    .sram_we_n      (sram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: inputs held while stalled, optional early drop of the request.
  task automatic run_op(input string tag, input logic w, input logic r,
                        input logic [31:0] alu, input logic [31:0] data,
                        input logic [17:0] exp_lo, input int drop_at,
                        input int exp_low, input logic [31:0] exp_mrv);
    int low;
    bit done;
    low  = 0;
    done = 0;
    @(negedge clk);
    mem_w_en = w; mem_r_en = r; alu_result = alu; src2_val = data;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (ready) begin
        done = 1;
      end else begin
        low++;
        if (exp_low > 1 && i >= 1 && i <= 4) begin
          check({tag, "_addr"}, 32'(sram_addr), 32'(i <= 2 ? exp_lo : (exp_lo | 18'd1)));
          check({tag, "_we_n"}, 32'(sram_we_n), 32'(!w));
          check({tag, "_oe"}, 32'(sram_dq_oe), 32'(w));
          if (w) check({tag, "_dq"}, 32'(sram_dq_out), 32'(i <= 2 ? data[15:0] : data[31:16]));
        end
        if (i == drop_at) begin
          mem_w_en = 1'b0; mem_r_en = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_low"}, 32'(low), 32'(exp_low));
    check({tag, "_mrv"}, mem_read_value, exp_mrv);
    check({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
    @(negedge clk);
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    #1;
    check({tag, "_idle_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    logic [17:0] addr_before;
    int          we_before;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = '0; src2_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_mrv", mem_read_value, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);

    run_op("st1032", 1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, -1, 5, 32'd0);
    check("mem_w4", 32'(sram_mem[4]), 32'h0000BEEF);
    check("mem_w5", 32'(sram_mem[5]), 32'h0000DEAD);
    run_op("ld1032", 0, 1, 32'd1032, 32'd0, 18'd4, -1, 5, 32'hDEADBEEF);
    run_op("ld1035", 0, 1, 32'd1035, 32'd0, 18'd4, -1, HIT_LOW, 32'hDEADBEEF);
    run_op("st_both", 1, 1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, -1, 5, 32'hDEADBEEF);
    check("mem_wrap_lo", 32'(sram_mem[18'h3FFFE]), 32'h0000F00D);
    check("mem_wrap_hi", 32'(sram_mem[18'h3FFFF]), 32'h0000CAFE);
    run_op("ld_drop", 0, 1, 32'd1020, 32'd0, 18'h3FFFE, 2, 5, 32'hCAFEF00D);

    // Repeat load of 1032: refills then hits when the cache is present.
    run_op("ld_fill", 0, 1, 32'd1032, 32'd0, 18'd4, -1, 5, 32'hDEADBEEF);
    addr_before = sram_addr;
    we_before   = we_cnt;
    run_op("ld_hit", 0, 1, 32'd1032, 32'd0, 18'd4, -1, HIT_LOW, 32'hDEADBEEF);
`ifdef SRAM_LAST_READ_CACHE_EN
    check("hit_addr_still", 32'(sram_addr), 32'(addr_before));
    check("hit_no_write", 32'(we_cnt), 32'(we_before));
`endif
    run_op("st_patch", 1, 0, 32'd1032, 32'h12345678, 18'd4, -1, 5, 32'hDEADBEEF);
    run_op("ld_patch", 0, 1, 32'd1032, 32'd0, 18'd4, -1, HIT_LOW, 32'h12345678);

    // Reset in the middle of a store's HI phase.
    @(negedge clk);
    mem_w_en = 1'b1; alu_result = 32'd1040; src2_val = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    check("mid_in_hi", 32'(sram_addr), 32'd9);
    rst = 1'b1; mem_w_en = 1'b0;
    @(negedge clk);
    #1;
    check("mid_we_n", 32'(sram_we_n), 32'd1);
    check("mid_oe", 32'(sram_dq_oe), 32'd0);
    check("mid_addr", 32'(sram_addr), 32'd0);
    check("mid_mrv", mem_read_value, 32'd0);
    check("mid_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_ready", 32'(ready), 32'd1);
    check("post_we_n", 32'(sram_we_n), 32'd1);
    run_op("ld_after", 0, 1, 32'd1032, 32'd0, 18'd4, -1, 5, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
